// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage in-order core: load-use bubbles, mul/div and
// data-memory waits, branch redirects, saturating perf counters and a memory-timeout flag.
module pipeline_hazard_ctrl #(
  parameter int AddrWidth    = 64,
  parameter int RegAddrWidth = 5,
  parameter int CntWidth     = 32,
  parameter int MemTimeout   = 255
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [RegAddrWidth-1:0] IdRs1Addr,
  input  logic [RegAddrWidth-1:0] IdRs2Addr,
  input  logic                    IdUsesRs1,
  input  logic                    IdUsesRs2,
  input  logic [RegAddrWidth-1:0] ExRdAddr,
  input  logic                    ExRdWriteEnable,
  input  logic                    ExIsLoad,
  input  logic                    MdStart,
  input  logic                    MdDone,
  input  logic                    MemReq,
  input  logic                    MemAck,
  input  logic                    JumpFlag,
  input  logic [AddrWidth-1:0]    JumpAddr,
  output logic                    PcHold,
  output logic                    IfIdHold,
  output logic                    IdExHold,
  output logic                    ExMemHold,
  output logic                    IfIdFlush,
  output logic                    IdExFlush,
  output logic                    RedirectValid,
  output logic [AddrWidth-1:0]    RedirectAddr,
  output logic [CntWidth-1:0]     StallCnt,
  output logic [CntWidth-1:0]     FlushCnt,
  output logic                    MemErr
);

  typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} state_t;

  // The timeout fires on the MemTimeout-th MEM_WAIT cycle, i.e. when the count of
  // already-completed wait cycles equals MemTimeout-1.
  localparam logic [7:0] TimeoutLast = 8'(MemTimeout - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic       set_err;
  logic       load_use;

  assign load_use = ExIsLoad && ExRdWriteEnable && (ExRdAddr != '0) &&
                    ((IdUsesRs1 && (IdRs1Addr == ExRdAddr)) ||
                     (IdUsesRs2 && (IdRs2Addr == ExRdAddr)));

  always_comb begin
    PcHold        = 1'b0;
    IfIdHold      = 1'b0;
    IdExHold      = 1'b0;
    ExMemHold     = 1'b0;
    IfIdFlush     = 1'b0;
    IdExFlush     = 1'b0;
    RedirectValid = 1'b0;
    RedirectAddr  = '0;
    set_err       = 1'b0;
    next_state    = state;
    if (Rst) begin
      case (state)
        RUN: begin
          if (MemReq && !MemAck) begin
            {PcHold, IfIdHold, IdExHold, ExMemHold} = 4'b1111;
            next_state = MEM_WAIT;
          end else if (MdStart && !MdDone) begin
            {PcHold, IfIdHold, IdExHold} = 3'b111;
            next_state = MD_WAIT;
          end else if (JumpFlag) begin
            IfIdFlush     = 1'b1;
            IdExFlush     = 1'b1;
            RedirectValid = 1'b1;
            RedirectAddr  = JumpAddr;
          end else if (load_use) begin
            PcHold    = 1'b1;
            IfIdHold  = 1'b1;
            IdExFlush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (MdDone) next_state = RUN;
          else {PcHold, IfIdHold, IdExHold} = 3'b111;
        end
        MEM_WAIT: begin
          // An ack arriving on the timeout cycle still completes cleanly.
          if (MemAck) begin
            next_state = RUN;
          end else if (wait_cnt == TimeoutLast) begin
            set_err    = 1'b1;
            next_state = RUN;
          end else begin
            {PcHold, IfIdHold, IdExHold, ExMemHold} = 4'b1111;
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= ((state == MEM_WAIT) && (next_state == MEM_WAIT)) ? wait_cnt + 8'd1 : 8'd0;
      if (set_err) MemErr <= 1'b1;
      if (PcHold && (StallCnt != '1)) StallCnt <= StallCnt + CntWidth'(1);
      if ((IfIdFlush || IdExFlush) && (FlushCnt != '1)) FlushCnt <= FlushCnt + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl, built with 4-bit counters and
// a 4-cycle memory timeout so saturation and timeout are reachable quickly.
module tb_pipeline_hazard_ctrl;

  localparam int AW = 64;
  localparam int RW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [RW-1:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_uses_rs1, id_uses_rs2, ex_rd_we, ex_is_load;
  logic          md_start, md_done, mem_req, mem_ack, jump_flag;
  logic [AW-1:0] jump_addr;
  logic          pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
  logic          if_id_flush, id_ex_flush, redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic          mem_err;

  int checks = 0;
  int failures = 0;

  pipeline_hazard_ctrl #(
    .AddrWidth(AW), .RegAddrWidth(RW), .CntWidth(CW), .MemTimeout(4)
  ) dut (
    .Clk(clk), .Rst(rst),
    .IdRs1Addr(id_rs1_addr), .IdRs2Addr(id_rs2_addr),
    .IdUsesRs1(id_uses_rs1), .IdUsesRs2(id_uses_rs2),
    .ExRdAddr(ex_rd_addr), .ExRdWriteEnable(ex_rd_we), .ExIsLoad(ex_is_load),
    .MdStart(md_start), .MdDone(md_done),
    .MemReq(mem_req), .MemAck(mem_ack),
    .JumpFlag(jump_flag), .JumpAddr(jump_addr),
    .PcHold(pc_hold), .IfIdHold(if_id_hold), .IdExHold(id_ex_hold), .ExMemHold(ex_mem_hold),
    .IfIdFlush(if_id_flush), .IdExFlush(id_ex_flush),
    .RedirectValid(redirect_valid), .RedirectAddr(redirect_addr),
    .StallCnt(stall_cnt), .FlushCnt(flush_cnt), .MemErr(mem_err)
  );

  always #5 clk = ~clk;

  // Packed view: {PcHold, IfIdHold, IdExHold, ExMemHold, IfIdFlush, IdExFlush, RedirectValid}
  logic [6:0] outs;
  assign outs = {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold, if_id_flush, id_ex_flush, redirect_valid};

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_rd_we = 1'b0; ex_is_load = 1'b0;
    md_start = 1'b0; md_done = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    jump_flag = 1'b0; jump_addr = '0;
  endtask

  task automatic load_use_x5();
    ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd5;
    id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
  endtask

  // Advance one clock; inputs change and are sampled well away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();

    // Enter MEM_WAIT, then pull reset asynchronously mid-cycle.
    mem_req = 1'b1;
    #1 check("mem_req_run_holds", 64'(outs), 64'(7'b1111000));
    cyc();
    #1 check("mem_wait_holds", 64'(outs), 64'(7'b1111000));
    rst = 1'b0;
    #1 check("reset_outs", 64'(outs), 64'(7'b0000000));
    check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("reset_flush_cnt", 64'(flush_cnt), 64'd0);
    check("reset_mem_err", 64'(mem_err), 64'd0);
    idle();
    cyc();
    rst = 1'b1;
    cyc();
    #1 check("run_idle_outs", 64'(outs), 64'(7'b0000000));

    // Load-use on rs2 = x5: one-cycle hold plus ID/EX bubble.
    load_use_x5();
    #1 check("load_use_outs", 64'(outs), 64'(7'b1100010));
    cyc();
    idle();
    #1 check("load_use_stall_cnt", 64'(stall_cnt), 64'd1);
    check("load_use_flush_cnt", 64'(flush_cnt), 64'd1);
    check("after_load_use_outs", 64'(outs), 64'(7'b0000000));

    // Load writing x0 never stalls.
    ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0; id_uses_rs2 = 1'b1;
    #1 check("load_x0_outs", 64'(outs), 64'(7'b0000000));
    cyc();
    idle();
    #1 check("load_x0_stall_cnt", 64'(stall_cnt), 64'd1);

    // Jump together with load-use: jump wins, flush only.
    load_use_x5();
    jump_flag = 1'b1; jump_addr = 64'h0000_0000_8000_0040;
    #1 check("jump_outs", 64'(outs), 64'(7'b0000111));
    check("jump_redirect_addr", redirect_addr, 64'h0000_0000_8000_0040);
    cyc();
    idle();
    #1 check("jump_flush_cnt", 64'(flush_cnt), 64'd2);
    check("jump_stall_cnt", 64'(stall_cnt), 64'd1);
    check("idle_redirect_addr", redirect_addr, 64'd0);

    // Mul/div: start cycle plus six wait cycles held, done on the seventh.
    md_start = 1'b1;
    #1 check("md_start_outs", 64'(outs), 64'(7'b1110000));
    cyc();
    md_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      jump_flag = (i == 3); jump_addr = 64'h1234;
      #1 check($sformatf("md_wait_outs_%0d", i), 64'(outs), 64'(7'b1110000));
      cyc();
    end
    jump_flag = 1'b0;
    md_done = 1'b1;
    #1 check("md_done_outs", 64'(outs), 64'(7'b0000000));
    cyc();
    idle();
    #1 check("md_stall_cnt", 64'(stall_cnt), 64'd8);
    check("md_flush_cnt", 64'(flush_cnt), 64'd2);

    // Memory request acknowledged after three held cycles.
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("mem_hold_%0d", i), 64'(outs), 64'(7'b1111000));
      cyc();
    end
    mem_ack = 1'b1;
    #1 check("mem_ack_outs", 64'(outs), 64'(7'b0000000));
    cyc();
    #1 check("mem_req_ack_same_cycle", 64'(outs), 64'(7'b0000000));
    cyc();
    idle();
    #1 check("mem_stall_cnt", 64'(stall_cnt), 64'd11);
    check("mem_no_err", 64'(mem_err), 64'd0);

    // Unacknowledged request: RUN cycle plus three MEM_WAIT cycles held, fourth times out.
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("timeout_hold_%0d", i), 64'(outs), 64'(7'b1111000));
      cyc();
    end
    #1 check("timeout_release_outs", 64'(outs), 64'(7'b0000000));
    check("timeout_err_not_yet", 64'(mem_err), 64'd0);
    cyc();
    idle();
    #1 check("timeout_mem_err", 64'(mem_err), 64'd1);
    check("timeout_stall_cnt", 64'(stall_cnt), 64'd15);
    jump_flag = 1'b1; jump_addr = 64'hABCD;
    #1 check("timeout_back_in_run", 64'(outs), 64'(7'b0000111));
    cyc();
    idle();
    #1 check("mem_err_sticky", 64'(mem_err), 64'd1);

    // Saturation: fresh reset, then twenty consecutive load-use stalls.
    rst = 1'b0;
    #1 check("reset2_mem_err", 64'(mem_err), 64'd0);
    cyc();
    rst = 1'b1;
    cyc();
    load_use_x5();
    repeat (20) cyc();
    idle();
    #1 check("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    check("sat_flush_cnt", 64'(flush_cnt), 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
